bcp_scheduler: RTL and testbench

//  Sequences the BCP datapath for one newly assigned variable. On start it reads the

---
 rtl/bcp_scheduler_if.sv | 64 ++++++
 rtl/bcp_scheduler.sv | 161 ++++++++++++++++
 tb/tb_bcp_scheduler.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bcp_scheduler_if.sv
// Handshake bundle between the BCP scheduler and its neighbours: control, the
// var start/end table, the clause evaluator and the imply stack.
interface bcp_scheduler_if #(
    parameter int VAR_BITS    = 8,
    parameter int CLAUSE_BITS = 10
);
    // control
    logic                   start;
    logic [VAR_BITS-1:0]    var_in;
    logic                   abort;
    logic                   bcp_busy;
    logic                   conflict;
    logic [CLAUSE_BITS-1:0] bcp_clause_idx;
    // var start/end table
    logic                   read_var_start_end;
    logic [VAR_BITS-1:0]    var_in_vse;
    logic [CLAUSE_BITS-1:0] start_clause;
    logic [CLAUSE_BITS-1:0] end_clause;
    // clause evaluator
    logic                   clause_valid;
    logic [CLAUSE_BITS-1:0] clause_idx;
    logic                   clause_ready;
    logic                   res_valid;
    logic                   res_ready;
    logic [CLAUSE_BITS-1:0] res_idx;
    logic                   res_conflict;
    logic                   res_unit;
    logic [VAR_BITS-1:0]    imp_var;
    logic                   imp_val;
    logic                   eval_flush;
    // imply stack
    logic                   push_imply;
    logic [VAR_BITS-1:0]    var_in_imply;
    logic                   val_in_imply;
    logic                   full_imply;

    // scheduler side
    modport master (
        input  start, var_in, abort,
        output bcp_busy, conflict, bcp_clause_idx,
        output read_var_start_end, var_in_vse,
        input  start_clause, end_clause,
        output clause_valid, clause_idx,
        input  clause_ready,
        input  res_valid, res_idx, res_conflict, res_unit, imp_var, imp_val,
        output res_ready, eval_flush,
        output push_imply, var_in_imply, val_in_imply,
        input  full_imply
    );

    // environment side (control, table, evaluator, imply stack)
    modport slave (
        output start, var_in, abort,
        input  bcp_busy, conflict, bcp_clause_idx,
        input  read_var_start_end, var_in_vse,
        output start_clause, end_clause,
        input  clause_valid, clause_idx,
        output clause_ready,
        output res_valid, res_idx, res_conflict, res_unit, imp_var, imp_val,
        input  res_ready, eval_flush,
        input  push_imply, var_in_imply, val_in_imply,
        output full_imply
    );
endinterface

// File: rtl/bcp_scheduler.sv
// Sequences BCP for one newly assigned variable: looks up its clause range, keeps up to
// MAX_OUT clause evaluations in flight, forwards unit results and records the first conflict.
module bcp_scheduler #(
    parameter int VAR_BITS    = 8,
    parameter int CLAUSE_BITS = 10,
    parameter int MAX_OUT     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    bcp_scheduler_if.master  bus
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0]       CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(MAX_OUT);
    localparam logic [CLAUSE_BITS-1:0] IDX_ONE = CLAUSE_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_TBL,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [VAR_BITS-1:0]    var_q, var_d;
    logic [CLAUSE_BITS-1:0] ptr_q, ptr_d;
    logic [CLAUSE_BITS-1:0] end_q, end_d;
    logic [CLAUSE_BITS-1:0] cidx_q, cidx_d;
    logic [CNT_W-1:0]       out_q, out_d;
    logic                   conflict_q, conflict_d;
    logic                   flush_q, flush_d;

    logic in_results;
    logic res_ready_int;
    logic res_fire;
    logic res_conf_fire;
    logic can_issue;
    logic issue_fire;
    logic push_int;

    always_comb begin
        in_results    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        res_ready_int = in_results && !bus.full_imply;
        // A result with nothing outstanding is stale; abort also swallows the result.
        res_fire      = bus.res_valid && res_ready_int && (out_q != '0) && !bus.abort;
        res_conf_fire = res_fire && bus.res_conflict;
        // Issuing stops the very cycle the first conflict arrives.
        can_issue     = (state_q == S_ISSUE) && (out_q < CNT_MAX) && (ptr_q != end_q)
                        && !conflict_q && !res_conf_fire && !bus.abort;
        issue_fire    = can_issue && bus.clause_ready;
        push_int      = res_fire && bus.res_unit && !conflict_q;
    end

    always_comb begin
        state_d    = state_q;
        var_d      = var_q;
        ptr_d      = ptr_q;
        end_d      = end_q;
        cidx_d     = cidx_q;
        out_d      = out_q;
        conflict_d = conflict_q;
        flush_d    = 1'b0;

        if (bus.abort) begin
            state_d    = S_IDLE;
            out_d      = '0;
            conflict_d = 1'b0;
            flush_d    = 1'b1;
        end else begin
            if (issue_fire && !res_fire) begin
                out_d = out_q + CNT_ONE;
            end else if (res_fire && !issue_fire) begin
                out_d = out_q - CNT_ONE;
            end

            if (res_conf_fire && !conflict_q) begin
                conflict_d = 1'b1;
                cidx_d     = bus.res_idx;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        var_d      = bus.var_in;
                        conflict_d = 1'b0;
                        cidx_d     = '0;
                        state_d    = S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    state_d = S_TBL;
                end
                S_TBL: begin
                    ptr_d = bus.start_clause;
                    end_d = bus.end_clause;
                    // Empty range: nothing can be outstanding, so the drain is immediate.
                    if (bus.end_clause <= bus.start_clause) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_fire) begin
                        ptr_d = ptr_q + IDX_ONE;
                    end
                    if (res_conf_fire || (ptr_q == end_q)
                        || (issue_fire && ((ptr_q + IDX_ONE) == end_q))) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_q == '0) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            var_q      <= '0;
            ptr_q      <= '0;
            end_q      <= '0;
            cidx_q     <= '0;
            out_q      <= '0;
            conflict_q <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            var_q      <= var_d;
            ptr_q      <= ptr_d;
            end_q      <= end_d;
            cidx_q     <= cidx_d;
            out_q      <= out_d;
            conflict_q <= conflict_d;
            flush_q    <= flush_d;
        end
    end

    assign bus.read_var_start_end = (state_q == S_LOOKUP);
    assign bus.var_in_vse         = var_q;
    assign bus.clause_valid       = can_issue;
    assign bus.clause_idx         = ptr_q;
    assign bus.res_ready          = res_ready_int;
    assign bus.eval_flush         = flush_q;
    assign bus.push_imply         = push_int;
    assign bus.var_in_imply       = push_int ? bus.imp_var : '0;
    assign bus.val_in_imply       = push_int && bus.imp_val;
    assign bus.bcp_busy           = (state_q != S_IDLE);
    assign bus.conflict           = conflict_q;
    assign bus.bcp_clause_idx     = cidx_q;

endmodule

// File: tb/tb_bcp_scheduler.sv
// Directed bench for bcp_scheduler: a small latency-programmable evaluator model feeds
// results back; each scenario's expected issue list, pushes and flags are hand-computed.
module tb_bcp_scheduler;

    logic clk;
    logic rst_n;

    bcp_scheduler_if #(.VAR_BITS(8), .CLAUSE_BITS(10)) b ();

    bcp_scheduler #(.VAR_BITS(8), .CLAUSE_BITS(10), .MAX_OUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // evaluator model and observation logs
    int          lat;
    logic [15:0] umask;
    logic [15:0] cmask;
    logic [9:0]  evq_idx[$];
    int          evq_age[$];
    logic [9:0]  issued[$];
    logic [7:0]  push_var[$];
    logic        push_val[$];
    int          push_cyc;
    int          max_inflight;
    int          busy_cycles;
    int          lookups;
    logic [7:0]  lookup_var;
    int          ready_while_full;
    int          cyc;
    int          full_until;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // One clock cycle: drive evaluator outputs, sample before the edge, update the model after.
    task automatic step();
        bit iss;
        bit rtk;
        logic [9:0] idx;
        if (evq_idx.size() > 0 && evq_age[0] >= lat) begin
            idx            = evq_idx[0];
            b.res_valid    = 1'b1;
            b.res_idx      = idx;
            b.res_conflict = cmask[idx[3:0]];
            b.res_unit     = umask[idx[3:0]];
            b.imp_var      = idx[7:0] + 8'd3;
            b.imp_val      = !idx[0];
        end else begin
            b.res_valid    = 1'b0;
            b.res_idx      = '0;
            b.res_conflict = 1'b0;
            b.res_unit     = 1'b0;
            b.imp_var      = '0;
            b.imp_val      = 1'b0;
        end
        b.full_imply = (cyc < full_until);
        #1;
        iss = b.clause_valid && b.clause_ready;
        rtk = b.res_valid && b.res_ready;
        idx = b.clause_idx;
        if (iss) issued.push_back(idx);
        if (b.push_imply) begin
            if (push_var.size() == 0) push_cyc = cyc;
            push_var.push_back(b.var_in_imply);
            push_val.push_back(b.val_in_imply);
        end
        if (b.full_imply && b.res_ready) ready_while_full++;
        if (b.bcp_busy) busy_cycles++;
        if (b.read_var_start_end) begin
            lookups++;
            lookup_var = b.var_in_vse;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rtk) begin
            void'(evq_idx.pop_front());
            void'(evq_age.pop_front());
        end
        foreach (evq_age[i]) evq_age[i]++;
        if (iss) begin
            evq_idx.push_back(idx);
            evq_age.push_back(0);
        end
        if (evq_idx.size() > max_inflight) max_inflight = evq_idx.size();
    endtask

    task automatic do_start(input logic [7:0] v, input logic [9:0] sc, input logic [9:0] ec);
        issued.delete();
        push_var.delete();
        push_val.delete();
        evq_idx.delete();
        evq_age.delete();
        push_cyc         = -1;
        max_inflight     = 0;
        busy_cycles      = 0;
        lookups          = 0;
        lookup_var       = '0;
        ready_while_full = 0;
        cyc              = 0;
        b.start_clause   = sc;
        b.end_clause     = ec;
        b.start          = 1'b1;
        b.var_in         = v;
        step();
        b.start          = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200 && b.bcp_busy; i++) step();
        check({tag, "_done"}, 32'(b.bcp_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        b.start        = 1'b1;
        b.var_in       = 8'd5;
        b.abort        = 1'b0;
        b.start_clause = '0;
        b.end_clause   = 10'd3;
        b.clause_ready = 1'b1;
        b.res_valid    = 1'b0;
        b.res_idx      = '0;
        b.res_conflict = 1'b0;
        b.res_unit     = 1'b0;
        b.imp_var      = '0;
        b.imp_val      = 1'b0;
        b.full_imply   = 1'b0;
        lat = 0; umask = '0; cmask = '0; full_until = 0; cyc = 0;
        push_cyc = -1; max_inflight = 0; busy_cycles = 0; lookups = 0;
        lookup_var = '0; ready_while_full = 0;

        // 1: reset holds everything cleared even with start asserted
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(b.bcp_busy), 32'd0);
        check("rst_read",   32'(b.read_var_start_end), 32'd0);
        check("rst_cvalid", 32'(b.clause_valid), 32'd0);
        check("rst_rready", 32'(b.res_ready), 32'd0);
        check("rst_flush",  32'(b.eval_flush), 32'd0);
        check("rst_conf",   32'(b.conflict), 32'd0);
        check("rst_cidx",   32'(b.bcp_clause_idx), 32'd0);
        b.start = 1'b0;
        rst_n   = 1'b1;
        step();
        step();
        check("post_rst_busy", 32'(b.bcp_busy), 32'd0);

        // 2: range 0..3, immediate results, no units
        lat = 0; umask = '0; cmask = '0;
        do_start(8'd5, 10'd0, 10'd3);
        check("t2_busy_rise", 32'(b.bcp_busy), 32'd1);
        wait_idle("t2");
        check("t2_lookups",   32'(lookups), 32'd1);
        check("t2_vse",       32'(lookup_var), 32'd5);
        check("t2_n_issued",  32'(issued.size()), 32'd3);
        check("t2_issue0",    32'(issued[0]), 32'd0);
        check("t2_issue2",    32'(issued[2]), 32'd2);
        check("t2_pushes",    32'(push_var.size()), 32'd0);
        check("t2_conflict",  32'(b.conflict), 32'd0);

        // 3: range 4..10, 6 unit (var 9,val 1), 7 and 8 conflict; one-cycle evaluator latency
        lat = 1; umask = 16'h0040; cmask = 16'h0180;
        do_start(8'd2, 10'd4, 10'd10);
        wait_idle("t3");
        check("t3_pushes",    32'(push_var.size()), 32'd1);
        check("t3_push_var",  32'(push_var[0]), 32'd9);
        check("t3_push_val",  32'(push_val[0]), 32'd1);
        check("t3_conflict",  32'(b.conflict), 32'd1);
        check("t3_cidx",      32'(b.bcp_clause_idx), 32'd7);
        check("t3_n_issued",  32'(issued.size()), 32'd5);
        check("t3_last_iss",  32'(issued[issued.size()-1]), 32'd8);
        step();
        check("t3_hold_cidx", 32'(b.bcp_clause_idx), 32'd7);

        // 5: empty range 3..3
        lat = 0; umask = '0; cmask = '0;
        do_start(8'd4, 10'd3, 10'd3);
        wait_idle("t5");
        check("t5_busy_cycles", 32'(busy_cycles), 32'd2);
        check("t5_n_issued",    32'(issued.size()), 32'd0);
        check("t5_conf_clear",  32'(b.conflict), 32'd0);

        // 4: 8-cycle latency, range 0..10, clause 0 unit while imply stack full until cycle 12
        lat = 8; umask = 16'h0001; cmask = '0; full_until = 12;
        do_start(8'd1, 10'd0, 10'd10);
        wait_idle("t4");
        full_until = 0;
        check("t4_max_inflight", 32'(max_inflight), 32'd4);
        check("t4_n_issued",     32'(issued.size()), 32'd10);
        check("t4_rdy_full",     32'(ready_while_full), 32'd0);
        check("t4_pushes",       32'(push_var.size()), 32'd1);
        check("t4_push_cyc",     32'(push_cyc), 32'd12);
        check("t4_push_var",     32'(push_var[0]), 32'd3);

        // 6: abort with 3 in flight, then a fresh run
        lat = 20; umask = '0; cmask = '0;
        do_start(8'd6, 10'd0, 10'd10);
        for (int i = 0; i < 20 && issued.size() < 3; i++) step();
        check("t6_inflight", 32'(issued.size()), 32'd3);
        b.abort = 1'b1;
        step();
        b.abort = 1'b0;
        evq_idx.delete();
        evq_age.delete();
        check("t6_flush",     32'(b.eval_flush), 32'd1);
        check("t6_busy",      32'(b.bcp_busy), 32'd0);
        check("t6_conf",      32'(b.conflict), 32'd0);
        check("t6_no_issue",  32'(issued.size()), 32'd3);
        step();
        check("t6_flush_end", 32'(b.eval_flush), 32'd0);
        lat = 0;
        do_start(8'd7, 10'd0, 10'd3);
        wait_idle("t6b");
        check("t6b_vse",      32'(lookup_var), 32'd7);
        check("t6b_n_issued", 32'(issued.size()), 32'd3);
        check("t6b_conflict", 32'(b.conflict), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
